// File: rtl/ldpc_dec_pkg.sv
// Shared defaults and sequencer state type for the 204/102 layered LDPC decoder.
package ldpc_dec_pkg;

    localparam int unsigned N_GRP_DEF  = 17;
    localparam int unsigned GRP_W_DEF  = 5;
    localparam int unsigned CN_LAT_DEF = 2;
    localparam int unsigned ITER_W_DEF = 5;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StDrain,
        StEval,
        StDone
    } sched_state_e;

endpackage

// File: rtl/cn_sched_pipe.sv
// Fixed-depth {vld, grp} delay line that tracks issued groups to writeback.
module cn_sched_pipe #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned GRP_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [GRP_W-1:0] in_grp,
    output logic             out_vld,
    output logic [GRP_W-1:0] out_grp,
    output logic             tail_empty
);

    logic [DEPTH-1:0] vld_q;
    logic [GRP_W-1:0] grp_q [DEPTH];
    logic [DEPTH-1:0] older;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                grp_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_vld;
            grp_q[0] <= in_grp;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                grp_q[i] <= grp_q[i-1];
            end
        end
    end

    // Shifting out the top stage leaves only entries still behind the one now leaving.
    assign older      = vld_q << 1;
    assign tail_empty = !in_vld && (older == '0);
    assign out_vld    = vld_q[DEPTH-1];
    assign out_grp    = grp_q[DEPTH-1];

endmodule

// File: rtl/ldpc_cn_sched.sv
// Check-node group / iteration sequencer. Early exit on convergence is enabled by
// defining CN_SCHED_EARLY_TERM_EN.
module ldpc_cn_sched
    import ldpc_dec_pkg::*;
#(
    parameter int unsigned N_GRP  = N_GRP_DEF,
    parameter int unsigned GRP_W  = GRP_W_DEF,
    parameter int unsigned CN_LAT = CN_LAT_DEF,
    parameter int unsigned ITER_W = ITER_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ITER_W-1:0] max_iter,
    input  logic              cn_stall,
    input  logic              par_ok,
    output logic              busy,
    output logic              done,
    output logic              cn_vld,
    output logic [GRP_W-1:0]  cn_grp,
    output logic              wb_vld,
    output logic [GRP_W-1:0]  wb_grp,
    output logic [ITER_W-1:0] iter_cnt,
    output logic              dec_ok
);

    localparam logic [GRP_W-1:0] LastGrp = GRP_W'(N_GRP - 1);

    sched_state_e      state_q, state_d;
    logic [GRP_W-1:0]  grp_q, grp_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [ITER_W-1:0] max_q, max_d;
    logic              all_ok_q, all_ok_d;
    logic              dec_ok_q, dec_ok_d;
    logic              tail_empty;
    logic              early_term;

`ifdef CN_SCHED_EARLY_TERM_EN
    assign early_term = all_ok_q;
`else
    assign early_term = 1'b0;
`endif

    cn_sched_pipe #(
        .DEPTH (CN_LAT),
        .GRP_W (GRP_W)
    ) u_pipe (
        .clk        (clk),
        .rst        (rst),
        .in_vld     (cn_vld),
        .in_grp     (cn_grp),
        .out_vld    (wb_vld),
        .out_grp    (wb_grp),
        .tail_empty (tail_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            grp_q    <= '0;
            iter_q   <= '0;
            max_q    <= '0;
            all_ok_q <= 1'b0;
            dec_ok_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grp_q    <= grp_d;
            iter_q   <= iter_d;
            max_q    <= max_d;
            all_ok_q <= all_ok_d;
            dec_ok_q <= dec_ok_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grp_d    = grp_q;
        iter_d   = iter_q;
        max_d    = max_q;
        all_ok_d = all_ok_q;
        dec_ok_d = dec_ok_q;
        busy     = 1'b0;
        done     = 1'b0;
        cn_vld   = 1'b0;
        cn_grp   = '0;

        if (wb_vld && !par_ok) begin
            all_ok_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    iter_d   = '0;
                    max_d    = (max_iter == '0) ? ITER_W'(1) : max_iter;
                    grp_d    = '0;
                    all_ok_d = 1'b1;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                busy   = 1'b1;
                cn_vld = !cn_stall;
                cn_grp = grp_q;
                if (!cn_stall) begin
                    if (grp_q == LastGrp) begin
                        state_d = StDrain;
                    end else begin
                        grp_d = grp_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                busy = 1'b1;
                if (tail_empty) begin
                    state_d = StEval;
                end
            end
            StEval: begin
                busy     = 1'b1;
                iter_d   = iter_q + 1'b1;
                dec_ok_d = all_ok_q;
                if ((iter_d == max_q) || early_term) begin
                    state_d = StDone;
                end else begin
                    grp_d    = '0;
                    all_ok_d = 1'b1;
                    state_d  = StIssue;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign iter_cnt = iter_q;
    assign dec_ok   = dec_ok_q;

endmodule

// File: tb/tb_ldpc_cn_sched.sv
// Directed self-checking bench for ldpc_cn_sched at default parameters.
module tb_ldpc_cn_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] max_iter;
    logic       cn_stall;
    logic       par_ok;
    logic       busy;
    logic       done;
    logic       cn_vld;
    logic [4:0] cn_grp;
    logic       wb_vld;
    logic [4:0] wb_grp;
    logic [4:0] iter_cnt;
    logic       dec_ok;

    int checks = 0;
    int errors = 0;

    int done_at;
    int issue_cnt [17];
    int order_err;
    int pipe_err;
    int busy_err;
    int vld_in_stall;

    always #5 clk = ~clk;

    ldpc_cn_sched dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .max_iter (max_iter),
        .cn_stall (cn_stall),
        .par_ok   (par_ok),
        .busy     (busy),
        .done     (done),
        .cn_vld   (cn_vld),
        .cn_grp   (cn_grp),
        .wb_vld   (wb_vld),
        .wb_grp   (wb_grp),
        .iter_cnt (iter_cnt),
        .dec_ok   (dec_ok)
    );

    // Starts a decode and observes it cycle by cycle (rel = cycles after the accepting edge).
    // par_mode: 0 always fail, 1 always pass, 2 fail only the first writeback of group 16.
    task automatic run(input logic [4:0] mi, input int par_mode, input int stall_from,
                       input int stall_len, input int extra_start_at, input int limit);
        logic       hv0, hv1;
        logic [4:0] hg0, hg1;
        int         exp_grp;
        bit         seen16;
        hv0 = 1'b0; hv1 = 1'b0; hg0 = '0; hg1 = '0;
        exp_grp = 0; seen16 = 1'b0;
        order_err = 0; pipe_err = 0; busy_err = 0; vld_in_stall = 0; done_at = -1;
        for (int g = 0; g < 17; g++) issue_cnt[g] = 0;
        @(negedge clk);
        start = 1'b1;
        max_iter = mi;
        @(posedge clk);
        for (int rel = 1; rel <= limit; rel++) begin
            @(negedge clk);
            start = (rel == extra_start_at);
            max_iter = (rel == extra_start_at) ? 5'd7 : mi;
            cn_stall = (rel >= stall_from) && (rel < stall_from + stall_len);
            case (par_mode)
                0: par_ok = 1'b0;
                1: par_ok = wb_vld;
                default: begin
                    par_ok = wb_vld && !(wb_grp == 5'd16 && !seen16);
                    if (wb_vld && wb_grp == 5'd16) seen16 = 1'b1;
                end
            endcase
            #1;
            if (cn_vld) begin
                if (cn_grp > 5'd16) order_err++;
                else issue_cnt[cn_grp]++;
                if (int'(cn_grp) != exp_grp) order_err++;
                exp_grp = (exp_grp == 16) ? 0 : exp_grp + 1;
            end
            if (cn_vld && cn_stall) vld_in_stall++;
            if (wb_vld !== hv1 || (wb_vld && wb_grp !== hg1)) pipe_err++;
            hv1 = hv0; hg1 = hg0; hv0 = cn_vld; hg0 = cn_grp;
            if (done === 1'b1) begin
                if (busy !== 1'b0) busy_err++;
                done_at = rel;
                break;
            end else if (busy !== 1'b1) begin
                busy_err++;
            end
        end
        start = 1'b0;
        cn_stall = 1'b0;
        par_ok = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; max_iter = '0; cn_stall = 1'b0; par_ok = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (cn_vld !== 1'b0) begin errors++; $display("FAIL reset_cn_vld got=%b exp=0", cn_vld); end
        checks++; if (cn_grp !== 5'd0) begin errors++; $display("FAIL reset_cn_grp got=%0d exp=0", cn_grp); end
        checks++; if (wb_vld !== 1'b0) begin errors++; $display("FAIL reset_wb_vld got=%b exp=0", wb_vld); end
        checks++; if (wb_grp !== 5'd0) begin errors++; $display("FAIL reset_wb_grp got=%0d exp=0", wb_grp); end
        checks++; if (iter_cnt !== 5'd0) begin errors++; $display("FAIL reset_iter_cnt got=%0d exp=0", iter_cnt); end
        checks++; if (dec_ok !== 1'b0) begin errors++; $display("FAIL reset_dec_ok got=%b exp=0", dec_ok); end
    endtask

    task automatic test_three_iter();
        int bad;
        run(5'd3, 0, 0, 0, 0, 100);
        bad = 0;
        for (int g = 0; g < 17; g++) if (issue_cnt[g] != 3) bad++;
        checks++; if (done_at != 61) begin errors++; $display("FAIL iter3_done_at got=%0d exp=61", done_at); end
        checks++; if (iter_cnt !== 5'd3) begin errors++; $display("FAIL iter3_iter_cnt got=%0d exp=3", iter_cnt); end
        checks++; if (dec_ok !== 1'b0) begin errors++; $display("FAIL iter3_dec_ok got=%b exp=0", dec_ok); end
        checks++; if (bad != 0) begin errors++; $display("FAIL iter3_issue_counts bad_groups=%0d exp=0", bad); end
        checks++; if (order_err != 0) begin errors++; $display("FAIL iter3_order got=%0d exp=0", order_err); end
        checks++; if (pipe_err != 0) begin errors++; $display("FAIL iter3_wb_delay got=%0d exp=0", pipe_err); end
        checks++; if (busy_err != 0) begin errors++; $display("FAIL iter3_busy got=%0d exp=0", busy_err); end
        @(negedge clk);
        #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL iter3_done_pulse got=%b exp=0", done); end
        checks++; if (iter_cnt !== 5'd3) begin errors++; $display("FAIL iter3_iter_hold got=%0d exp=3", iter_cnt); end
    endtask

    task automatic test_converge();
        int exp_done;
        int exp_iter;
`ifdef CN_SCHED_EARLY_TERM_EN
        exp_done = 21; exp_iter = 1;
`else
        exp_done = 201; exp_iter = 10;
`endif
        run(5'd10, 1, 0, 0, 0, 240);
        checks++; if (done_at != exp_done) begin errors++; $display("FAIL conv_done_at got=%0d exp=%0d", done_at, exp_done); end
        checks++; if (int'(iter_cnt) != exp_iter) begin errors++; $display("FAIL conv_iter_cnt got=%0d exp=%0d", iter_cnt, exp_iter); end
        checks++; if (dec_ok !== 1'b1) begin errors++; $display("FAIL conv_dec_ok got=%b exp=1", dec_ok); end
        checks++; if (issue_cnt[16] != exp_iter) begin errors++; $display("FAIL conv_issue16 got=%0d exp=%0d", issue_cnt[16], exp_iter); end
    endtask

    task automatic test_late_pass();
        // First iteration fails only on group 16; the second passes everywhere.
        run(5'd2, 2, 0, 0, 0, 80);
        checks++; if (done_at != 41) begin errors++; $display("FAIL late_done_at got=%0d exp=41", done_at); end
        checks++; if (iter_cnt !== 5'd2) begin errors++; $display("FAIL late_iter_cnt got=%0d exp=2", iter_cnt); end
        checks++; if (dec_ok !== 1'b1) begin errors++; $display("FAIL late_dec_ok got=%b exp=1", dec_ok); end
    endtask

    task automatic test_stall();
        int bad;
        run(5'd1, 0, 5, 5, 0, 60);
        bad = 0;
        for (int g = 0; g < 17; g++) if (issue_cnt[g] != 1) bad++;
        checks++; if (done_at != 26) begin errors++; $display("FAIL stall_done_at got=%0d exp=26", done_at); end
        checks++; if (bad != 0) begin errors++; $display("FAIL stall_issue_counts bad_groups=%0d exp=0", bad); end
        checks++; if (vld_in_stall != 0) begin errors++; $display("FAIL stall_vld_while_stalled got=%0d exp=0", vld_in_stall); end
        checks++; if (order_err != 0) begin errors++; $display("FAIL stall_order got=%0d exp=0", order_err); end
        checks++; if (pipe_err != 0) begin errors++; $display("FAIL stall_wb_delay got=%0d exp=0", pipe_err); end
        checks++; if (busy_err != 0) begin errors++; $display("FAIL stall_busy got=%0d exp=0", busy_err); end
    endtask

    task automatic test_max_zero();
        run(5'd0, 1, 0, 0, 5, 60);
        checks++; if (done_at != 21) begin errors++; $display("FAIL max0_done_at got=%0d exp=21", done_at); end
        checks++; if (iter_cnt !== 5'd1) begin errors++; $display("FAIL max0_iter_cnt got=%0d exp=1", iter_cnt); end
        checks++; if (issue_cnt[0] != 1) begin errors++; $display("FAIL max0_issue0 got=%0d exp=1", issue_cnt[0]); end
        checks++; if (order_err != 0) begin errors++; $display("FAIL max0_order got=%0d exp=0", order_err); end
    endtask

    task automatic test_reset_mid();
        int n_done;
        int n_wb;
        @(negedge clk);
        start = 1'b1;
        max_iter = 5'd3;
        @(posedge clk);
        for (int rel = 1; rel <= 8; rel++) begin
            @(negedge clk);
            start = 1'b0;
            if (rel == 8) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        checks++; if (wb_vld !== 1'b0) begin errors++; $display("FAIL rstmid_wb_vld got=%b exp=0", wb_vld); end
        checks++; if (iter_cnt !== 5'd0) begin errors++; $display("FAIL rstmid_iter_cnt got=%0d exp=0", iter_cnt); end
        checks++; if (cn_vld !== 1'b0) begin errors++; $display("FAIL rstmid_cn_vld got=%b exp=0", cn_vld); end
        n_done = 0;
        n_wb = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            #1;
            if (done === 1'b1) n_done++;
            if (wb_vld === 1'b1) n_wb++;
        end
        checks++; if (n_done != 0) begin errors++; $display("FAIL rstmid_no_done got=%0d exp=0", n_done); end
        checks++; if (n_wb != 0) begin errors++; $display("FAIL rstmid_no_wb got=%0d exp=0", n_wb); end
        run(5'd1, 1, 0, 0, 0, 40);
        checks++; if (done_at != 21) begin errors++; $display("FAIL rstmid_rerun_done_at got=%0d exp=21", done_at); end
        checks++; if (iter_cnt !== 5'd1) begin errors++; $display("FAIL rstmid_rerun_iter got=%0d exp=1", iter_cnt); end
        checks++; if (dec_ok !== 1'b1) begin errors++; $display("FAIL rstmid_rerun_dec_ok got=%b exp=1", dec_ok); end
    endtask

    initial begin
        test_reset();
        test_three_iter();
        test_converge();
        test_late_pass();
        test_stall();
        test_max_zero();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
